// File: rtl/spi_seq_pkg.sv
// Shared constants, state encoding and request bundle for the SPI transfer sequencer.
// Bus word addresses are 14-bit IO bus word addresses (byte address bits 15:2).
package spi_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CFG_MODE = 3'd1,
    CFG_SDIV = 3'd2,
    FLUSH    = 3'd3,
    XFER     = 3'd4,
    DONE     = 3'd5,
    ABORT    = 3'd6,
    ERR      = 3'd7
  } state_t;

  localparam logic [13:0] ADR_MODE = 14'h3C80;
  localparam logic [13:0] ADR_SDIV = 14'h3C81;
  localparam logic [13:0] ADR_DATA = 14'h3C82;
  localparam logic [13:0] ADR_CTRL = 14'h3C83;

  localparam logic [31:0] FLUSH_CMD    = 32'h0000_0400;
  localparam logic [16:0] INFLIGHT_MAX = 17'd4;
  localparam logic [11:0] TIMEOUT      = 12'd4095;
  localparam logic [7:0]  DUMMY        = 8'hFF;
  localparam int          RX_EMPTY_BIT = 9;

  typedef struct packed {
    logic [2:0]  cmd_len;
    logic [31:0] hdr;
    logic [15:0] rd_len;
    logic [31:0] mode;
    logic [9:0]  sdiv;
  } req_t;

  // Header bytes go out MSB byte first.
  function automatic logic [7:0] hdr_byte(input logic [31:0] hdr, input logic [1:0] idx);
    case (idx)
      2'd0:    hdr_byte = hdr[31:24];
      2'd1:    hdr_byte = hdr[23:16];
      2'd2:    hdr_byte = hdr[15:8];
      default: hdr_byte = hdr[7:0];
    endcase
  endfunction

endpackage

// File: rtl/spi_xfer_seq.sv
// SPI transfer sequencer: configures the SPI block, then streams header/dummy bytes out and payload bytes in.
// One bus op per cycle, poll returns consumed one cycle later; rd_valid holds until rd_ready and stalls polling.
module spi_xfer_seq
  import spi_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [2:0]  cmd_len,
  input  logic [31:0] hdr_data,
  input  logic [15:0] rd_len,
  input  logic [31:0] cfg_mode,
  input  logic [9:0]  cfg_sdiv,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        io_we,
  output logic [15:2] io_wadr,
  output logic [31:0] io_wdata,
  output logic [15:2] io_radr,
  output logic        io_radr_en,
  input  logic [31:0] io_rdata,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  input  logic        rd_ready
);

  state_t      state_q, state_d;
  req_t        req_q;
  logic [16:0] total, tx_cnt, rx_cnt, inflight;
  logic [11:0] tmo_cnt;
  logic        rd_pend;
  logic        rd_valid_q;
  logic [7:0]  rd_data_q;
  logic        err_q;
  logic        push_ok, poll_ok, do_push, do_poll, rx_byte, rx_empty;
  logic        unused_rdata;

  assign total    = {14'd0, req_q.cmd_len} + {1'b0, req_q.rd_len};
  assign inflight = tx_cnt - rx_cnt;
  assign push_ok  = (tx_cnt < total) && (inflight < INFLIGHT_MAX);
  assign poll_ok  = (inflight != 17'd0) && !rd_pend && !rd_valid_q;
  // Polls win over pushes; nothing new is issued in the cycle abort arrives.
  assign do_poll  = (state_q == XFER) && !abort && poll_ok;
  assign do_push  = (state_q == XFER) && !abort && push_ok && !poll_ok;
  assign rx_byte  = rd_pend && !io_rdata[RX_EMPTY_BIT];
  assign rx_empty = rd_pend && io_rdata[RX_EMPTY_BIT];
  assign unused_rdata = ^{io_rdata[31:10], io_rdata[8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (start) state_d = CFG_MODE;
      CFG_MODE: state_d = CFG_SDIV;
      CFG_SDIV: state_d = FLUSH;
      FLUSH:    state_d = (total == 17'd0) ? DONE : XFER;
      XFER: begin
        if (rx_empty && (tmo_cnt == TIMEOUT - 12'd1)) state_d = ERR;
        else if ((rx_cnt == total) && !rd_valid_q)    state_d = DONE;
      end
      DONE, ABORT, ERR: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if ((state_q != IDLE) && abort) state_d = ABORT;
  end

  always_comb begin
    io_we      = 1'b0;
    io_wadr    = '0;
    io_wdata   = '0;
    io_radr    = '0;
    io_radr_en = 1'b0;
    case (state_q)
      CFG_MODE: begin
        io_we    = 1'b1;
        io_wadr  = ADR_MODE;
        io_wdata = req_q.mode;
      end
      CFG_SDIV: begin
        io_we    = 1'b1;
        io_wadr  = ADR_SDIV;
        io_wdata = {22'd0, req_q.sdiv};
      end
      FLUSH, ABORT, ERR: begin
        io_we    = 1'b1;
        io_wadr  = ADR_CTRL;
        io_wdata = FLUSH_CMD;
      end
      XFER: begin
        if (do_poll) begin
          io_radr_en = 1'b1;
          io_radr    = ADR_CTRL;
        end else if (do_push) begin
          io_we    = 1'b1;
          io_wadr  = ADR_DATA;
          io_wdata = {24'd0, (tx_cnt < {14'd0, req_q.cmd_len}) ?
                             hdr_byte(req_q.hdr, tx_cnt[1:0]) : DUMMY};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q      <= '0;
      tx_cnt     <= '0;
      rx_cnt     <= '0;
      tmo_cnt    <= '0;
      rd_pend    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      rd_pend <= do_poll;
      if ((state_q == IDLE) && start) begin
        req_q   <= {cmd_len, hdr_data, rd_len, cfg_mode, cfg_sdiv};
        err_q   <= 1'b0;
        tx_cnt  <= '0;
        rx_cnt  <= '0;
        tmo_cnt <= '0;
      end
      if (do_push) tx_cnt <= tx_cnt + 17'd1;
      if (state_q == ERR) err_q <= 1'b1;
      if (rd_valid_q && rd_ready) rd_valid_q <= 1'b0;
      if ((state_q == XFER) && !abort) begin
        if (rx_byte) begin
          rx_cnt  <= rx_cnt + 17'd1;
          tmo_cnt <= '0;
          // Header-phase returns are just the slave clocking in our command.
          if (rx_cnt >= {14'd0, req_q.cmd_len}) begin
            rd_data_q  <= io_rdata[7:0];
            rd_valid_q <= 1'b1;
          end
        end else if (rx_empty) begin
          tmo_cnt <= tmo_cnt + 12'd1;
        end
      end
      if ((state_q != IDLE) && abort) rd_valid_q <= 1'b0;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign err      = err_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: doc/spi_xfer_seq.md
SPI_XFER_SEQ -- requirements
Module: spi_xfer_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic rises on clk.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: one-cycle transaction request.
REQ-004 SHALL have port abort, input, 1 bit: cancels the active transaction.
REQ-005 SHALL have port cmd_len, input, 3 bits: header byte count, legal range 0..4.
REQ-006 SHALL have port hdr_data, input, 32 bits: header bytes, sent MSB byte first.
REQ-007 SHALL have port rd_len, input, 16 bits: payload bytes to read.
REQ-008 SHALL have port cfg_mode, input, 32 bits: value written to the SPI MODE register.
REQ-009 SHALL have port cfg_sdiv, input, 10 bits: value written to the SPI SDIV register.
REQ-010 SHALL have port busy, output, 1 bit: high while not in IDLE.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port err, output, 1 bit: sticky timeout flag, cleared by an accepted start.
REQ-013 SHALL have ports io_we (1), io_wadr (15:2), io_wdata (32), io_radr (15:2), io_radr_en (1), all outputs: master side of the IO bus.
REQ-014 SHALL have port io_rdata, input, 32 bits: read return, valid exactly one cycle after io_radr_en.
REQ-015 SHALL have ports rd_valid (output, 1), rd_data (output, 8) and rd_ready (input, 1): payload stream.

Function
REQ-016 SHALL implement states IDLE, CFG_MODE, CFG_SDIV, FLUSH, XFER, DONE, ABORT and ERR, with IDLE as the reset state.
REQ-017 SHALL accept start only in IDLE; start SHALL be ignored in every other state.
REQ-018 SHALL latch all request inputs when start is accepted and clear err at the same time.
REQ-019 SHALL issue one write per state in this order: CFG_MODE writes word address 0x3C80 with cfg_mode; CFG_SDIV writes 0x3C81 with cfg_sdiv; FLUSH writes 0x3C83 with bit10=1 and all other bits 0.
REQ-020 SHALL compute total T = cmd_len + rd_len in 17 bits; when T=0, FLUSH SHALL go directly to DONE.
REQ-021 SHALL, in XFER, send byte i as follows: for i < cmd_len, hdr_data[31-8i -: 8]; otherwise 0xFF. Each byte is one write to 0x3C82 with the byte in wdata[7:0].
REQ-022 SHALL push a byte only when tx_cnt < T and inflight < 4, where inflight = tx_cnt - rx_cnt.
REQ-023 SHALL poll by reading 0x3C83 when inflight > 0, no read is outstanding, and rd_valid is low.
REQ-024 SHALL issue at most one bus operation per cycle; io_we and io_radr_en are never high together.
REQ-025 SHALL prefer a poll over a push when both are eligible.
REQ-026 SHALL treat a poll return as a byte when io_rdata[9]=0, and as empty when io_rdata[9]=1.
REQ-027 SHALL, on a received byte, increment rx_cnt; the byte SHALL be discarded when rx_cnt < cmd_len, otherwise loaded into rd_data with rd_valid=1.
REQ-028 SHALL hold rd_valid and rd_data stable until rd_ready=1; the transfer occurs in any cycle with rd_valid & rd_ready.
REQ-029 SHALL count empty polls in a 12-bit counter, reset it on every received byte, and move to ERR when it reaches 4095.
REQ-030 SHALL enter DONE when rx_cnt == T and rd_valid is low; DONE SHALL assert done for one cycle, then return to IDLE.
REQ-031 SHALL, on abort in any non-IDLE state, enter ABORT next cycle, drop rd_valid, issue a FLUSH write, then return to IDLE without asserting done.
REQ-032 SHALL, in ERR, set err=1, issue a FLUSH write, then return to IDLE.
REQ-033 SHALL give abort priority over a simultaneous byte receive or timeout.
REQ-034 SHALL keep all bus outputs at 0 whenever no operation is being issued.

Reset
REQ-035 SHALL, on rst, clear asynchronously: state=IDLE; busy, done, err, rd_valid, io_we and io_radr_en = 0; all address, data and counter registers = 0.
REQ-036 SHALL, after reset mid-transaction, issue no bus operation until the next accepted start.

Structure
REQ-037 SHALL place register addresses 0x3C80..0x3C83, the state encoding, INFLIGHT_MAX=4, TIMEOUT=4095 and DUMMY=0xFF in the shared package spi_seq_pkg.
REQ-038 SHALL be a single module with no sub-module.

Verification
REQ-039 SHALL verify: cmd_len=4, hdr=0x03001000, rd_len=2, with an SPI model echoing 0xA5,0x5A after the header -> writes 3C80, 3C81, 3C83(0x400), then MOSI bytes 03,00,10,00,FF,FF; stream outputs A5, 5A; done pulses once.
REQ-040 SHALL verify: cmd_len=0, rd_len=0 -> exactly three config writes, then done; no MOSI write and no poll.
REQ-041 SHALL verify: rd_len=20 with rd_ready held low for 50 cycles -> inflight never exceeds 4; no poll while rd_valid=1; all 20 bytes delivered in order.
REQ-042 SHALL verify: miso permanently empty -> err=1 after 4095 empty polls, a FLUSH write is issued, busy drops, and done is never asserted.
REQ-043 SHALL verify: abort during the 3rd payload byte -> ABORT, one FLUSH write, IDLE; a following start is accepted and err=0.
